// File: rtl/dds_sweep_gen.sv
// Linear phase-step sweep generator feeding DDS_Core.
// Steps start->stop per dwell; one-shot, sawtooth or triangle.
module dds_sweep_gen #(
  parameter int _PHASE_WORD_WIDTH = 32,
  parameter int _DWELL_WIDTH      = 24
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_start,
  input  logic                         i_abort,
  input  logic [1:0]                   i_mode,
  input  logic [_PHASE_WORD_WIDTH-1:0] i_start_step,
  input  logic [_PHASE_WORD_WIDTH-1:0] i_stop_step,
  input  logic [_PHASE_WORD_WIDTH-1:0] i_step_delta,
  input  logic [_DWELL_WIDTH-1:0]      i_dwell,
  output logic [_PHASE_WORD_WIDTH-1:0] o_phase_step,
  output logic                         o_busy,
  output logic                         o_sync,
  output logic                         o_done,
  output logic                         o_err,
  output logic                         o_dir
);

  localparam int W  = _PHASE_WORD_WIDTH;
  localparam int DW = _DWELL_WIDTH;
  localparam logic [DW-1:0] ONE = DW'(1);

  typedef enum logic [1:0] {
    IDLE, UP, DOWN, FINISH
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   phase_q, phase_d;
  logic [W-1:0]   start_q, start_d;
  logic [W-1:0]   stop_q, stop_d;
  logic [W-1:0]   delta_q, delta_d;
  logic [DW-1:0]  dwell_q, dwell_d;
  logic [DW-1:0]  cnt_q, cnt_d;
  logic [1:0]     mode_q, mode_d;
  logic           busy_q, busy_d;
  logic           sync_q, sync_d;
  logic           done_q, done_d;
  logic           err_q, err_d;
  logic           dir_q, dir_d;

  logic [W:0]     up_sum, dn_diff;
  logic           up_clamp, dn_clamp;
  logic           expire, cfg_bad;
  logic [DW-1:0]  dwell_in;

  // Next-point candidates; carry/borrow in the top bit.
  assign up_sum   = {1'b0, phase_q} + {1'b0, delta_q};
  assign dn_diff  = {1'b0, phase_q} - {1'b0, delta_q};
  assign up_clamp = up_sum[W] || (up_sum[W-1:0] >= stop_q);
  assign dn_clamp = dn_diff[W] || (dn_diff[W-1:0] <= start_q);
  assign expire   = (cnt_q == ONE);
  assign cfg_bad  = (i_start_step >= i_stop_step) ||
                    (i_step_delta == '0);
  assign dwell_in = (i_dwell == '0) ? ONE : i_dwell;

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    start_d = start_q;
    stop_d  = stop_q;
    delta_d = delta_q;
    dwell_d = dwell_q;
    mode_d  = mode_q;
    busy_d  = busy_q;
    dir_d   = dir_q;
    sync_d  = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    cnt_d   = cnt_q;
    if (state_q != IDLE) begin
      cnt_d = expire ? dwell_q : cnt_q - ONE;
    end
    if (state_q != IDLE && i_abort) begin
      state_d = IDLE;
      busy_d  = 1'b0;
      dir_d   = 1'b0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (i_start && !i_abort) begin
            start_d = i_start_step;
            stop_d  = i_stop_step;
            delta_d = i_step_delta;
            dwell_d = dwell_in;
            mode_d  = i_mode;
            cnt_d   = dwell_in;
            phase_d = i_start_step;
            busy_d  = 1'b1;
            sync_d  = 1'b1;
            dir_d   = 1'b0;
            state_d = cfg_bad ? FINISH : UP;
          end
        end
        UP: begin
          if (expire) begin
            if (phase_q == stop_q) begin
              unique case (mode_q)
                2'd1: begin
                  phase_d = start_q;
                  sync_d  = 1'b1;
                end
                2'd2: begin
                  state_d = DOWN;
                  dir_d   = 1'b1;
                  phase_d = dn_clamp ? start_q : dn_diff[W-1:0];
                  sync_d  = dn_clamp;
                end
                default: begin
                  state_d = IDLE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  cnt_d   = '0;
                end
              endcase
            end else begin
              phase_d = up_clamp ? stop_q : up_sum[W-1:0];
            end
          end
        end
        DOWN: begin
          if (expire) begin
            if (phase_q == start_q) begin
              state_d = UP;
              dir_d   = 1'b0;
              phase_d = up_clamp ? stop_q : up_sum[W-1:0];
            end else begin
              phase_d = dn_clamp ? start_q : dn_diff[W-1:0];
              sync_d  = dn_clamp;
            end
          end
        end
        FINISH: begin
          // Only reached on a rejected config.
          if (expire) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            err_d   = 1'b1;
            cnt_d   = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      phase_q <= '0;
      start_q <= '0;
      stop_q  <= '0;
      delta_q <= '0;
      dwell_q <= '0;
      cnt_q   <= '0;
      mode_q  <= '0;
      busy_q  <= 1'b0;
      sync_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      start_q <= start_d;
      stop_q  <= stop_d;
      delta_q <= delta_d;
      dwell_q <= dwell_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      busy_q  <= busy_d;
      sync_q  <= sync_d;
      done_q  <= done_d;
      err_q   <= err_d;
      dir_q   <= dir_d;
    end
  end

  assign o_phase_step = phase_q;
  assign o_busy       = busy_q;
  assign o_sync       = sync_q;
  assign o_done       = done_q;
  assign o_err        = err_q;
  assign o_dir        = dir_q;

endmodule

// File: tb/tb_dds_sweep_gen.sv
// Directed bench for dds_sweep_gen.
// Cycle c0 = the cycle i_start is presented.
module tb_dds_sweep_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, abort;
  logic [1:0]  mode;
  logic [31:0] s_step, e_step, d_step;
  logic [23:0] dwell;
  logic [31:0] phase;
  logic        busy, sync, done, err, dir;

  int checks = 0;
  int errors = 0;

  dds_sweep_gen dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_start      (start),
    .i_abort      (abort),
    .i_mode       (mode),
    .i_start_step (s_step),
    .i_stop_step  (e_step),
    .i_step_delta (d_step),
    .i_dwell      (dwell),
    .o_phase_step (phase),
    .o_busy       (busy),
    .o_sync       (sync),
    .o_done       (done),
    .o_err        (err),
    .o_dir        (dir)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input logic [31:0] s, input logic [31:0] e,
                    input logic [31:0] d, input logic [23:0] w,
                    input logic [1:0] m);
    s_step = s;
    e_step = e;
    d_step = d;
    dwell  = w;
    mode   = m;
    start  = 1'b1;
    tick();
    start  = 1'b0;
  endtask

  logic [31:0] ep [9];
  logic        ed [9];
  logic        es [9];

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    mode  = 2'd0;
    s_step = '0;
    e_step = '0;
    d_step = '0;
    dwell  = '0;
    #12;
    chk("rst_phase", phase, 32'd0);
    chk("rst_flags", {27'd0, busy, sync, done, err, dir}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Nominal one-shot; stop input changed after start is ignored.
    go(100, 130, 10, 3, 0);
    e_step = 32'd999;
    for (int c = 1; c <= 14; c++) begin
      chk($sformatf("nom_phase_c%0d", c), phase,
          (c <= 12) ? 32'(100 + 10 * ((c - 1) / 3)) : 32'd130);
      chk($sformatf("nom_sync_c%0d", c), 32'(sync), 32'(c == 1));
      chk($sformatf("nom_done_c%0d", c), 32'(done), 32'(c == 13));
      chk($sformatf("nom_busy_c%0d", c), 32'(busy), 32'(c <= 12));
      chk($sformatf("nom_err_c%0d", c), 32'(err), 32'd0);
      tick();
    end

    // Clamp to stop, dwell 1.
    ep[0:3] = '{100, 110, 120, 125};
    go(100, 125, 10, 1, 0);
    for (int c = 1; c <= 4; c++) begin
      chk($sformatf("clp_phase_c%0d", c), phase, ep[c-1]);
      chk($sformatf("clp_done_c%0d", c), 32'(done), 32'd0);
      tick();
    end
    chk("clp_done", 32'(done), 32'd1);
    chk("clp_err", 32'(err), 32'd0);
    chk("clp_busy", 32'(busy), 32'd0);
    chk("clp_hold", phase, 32'd125);
    tick();

    // Carry-out clamp, dwell 2.
    go(32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h20, 2, 0);
    ep[0:3] = '{32'hFFFF_FFF0, 32'hFFFF_FFF0,
                32'hFFFF_FFFF, 32'hFFFF_FFFF};
    for (int c = 1; c <= 4; c++) begin
      chk($sformatf("ovf_phase_c%0d", c), phase, ep[c-1]);
      tick();
    end
    chk("ovf_done", 32'(done), 32'd1);
    chk("ovf_hold", phase, 32'hFFFF_FFFF);
    tick();

    // Triangle.
    ep = '{0, 10, 20, 10, 0, 10, 20, 10, 0};
    ed = '{0, 0, 0, 1, 1, 0, 0, 1, 1};
    es = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
    go(0, 20, 10, 1, 2);
    for (int c = 1; c <= 9; c++) begin
      chk($sformatf("tri_phase_c%0d", c), phase, ep[c-1]);
      chk($sformatf("tri_dir_c%0d", c), 32'(dir), 32'(ed[c-1]));
      chk($sformatf("tri_sync_c%0d", c), 32'(sync), 32'(es[c-1]));
      chk($sformatf("tri_busy_c%0d", c), 32'(busy), 32'd1);
      chk($sformatf("tri_done_c%0d", c), 32'(done), 32'd0);
      tick();
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("tri_abort_busy", 32'(busy), 32'd0);
    chk("tri_abort_dir", 32'(dir), 32'd0);
    chk("tri_abort_done", 32'(done), 32'd0);
    tick();

    // Sawtooth, then abort with a same-cycle start.
    ep[0:4] = '{5, 6, 7, 5, 6};
    es[0:4] = '{1, 0, 0, 1, 0};
    go(5, 7, 1, 1, 1);
    for (int c = 1; c <= 5; c++) begin
      chk($sformatf("saw_phase_c%0d", c), phase, ep[c-1]);
      chk($sformatf("saw_sync_c%0d", c), 32'(sync), 32'(es[c-1]));
      if (c < 5) tick();
    end
    abort  = 1'b1;
    start  = 1'b1;
    s_step = 32'd99;
    tick();
    abort = 1'b0;
    start = 1'b0;
    chk("abt_busy", 32'(busy), 32'd0);
    chk("abt_phase", phase, 32'd6);
    chk("abt_done", 32'(done), 32'd0);
    chk("abt_sync", 32'(sync), 32'd0);
    tick();
    chk("abt_idle_busy", 32'(busy), 32'd0);
    chk("abt_idle_phase", phase, 32'd6);

    // Invalid config: start == stop.
    go(50, 50, 1, 4, 0);
    for (int c = 1; c <= 6; c++) begin
      chk($sformatf("err_phase_c%0d", c), phase, 32'd50);
      chk($sformatf("err_done_c%0d", c), 32'(done), 32'(c == 5));
      chk($sformatf("err_err_c%0d", c), 32'(err), 32'(c == 5));
      chk($sformatf("err_busy_c%0d", c), 32'(busy), 32'(c <= 4));
      tick();
    end

    // Zero delta is also invalid.
    go(3, 9, 0, 1, 0);
    tick();
    chk("zd_err", 32'(err), 32'd1);
    chk("zd_phase", phase, 32'd3);
    tick();

    // Dwell 0 behaves as 1.
    go(0, 2, 1, 0, 0);
    chk("dw0_c1", phase, 32'd0);
    tick();
    chk("dw0_c2", phase, 32'd1);
    tick();
    chk("dw0_c3", phase, 32'd2);
    tick();
    chk("dw0_done", 32'(done), 32'd1);
    tick();

    // Mode 3 acts as one-shot.
    go(0, 1, 1, 1, 3);
    tick();
    chk("m3_c2", phase, 32'd1);
    tick();
    chk("m3_done", 32'(done), 32'd1);
    tick();

    // Asynchronous reset mid-sweep.
    go(100, 130, 10, 3, 2);
    tick();
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_phase", phase, 32'd0);
    chk("arst_flags", {27'd0, busy, sync, done, err, dir}, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("arst_idle", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
